// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Holds the default widths, reset half-period and the common half-period presets.
// Also holds the helper that sizes the channel index.
package clock_divider_pkg;

  localparam int CNT_W_DEF    = 32;
  localparam int RST_HALF_DEF = 50_000;

  // Half-periods in 100 MHz Clock cycles.
  localparam int HALF_1KHZ = 50_000;
  localparam int HALF_1HZ  = 50_000_000;
  localparam int HALF_SCAN = 100_000;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: half-period counter, active/pending half and registered 50% output plus tick.
// Latency: a pending half is applied at the next toggle boundary, or one cycle after acceptance if stopped.
// Backpressure: one outstanding update; pend_vld stays high until applied. SyncReq via CLKDIV_PHASE_SYNC_EN.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int                CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0]  RST_HALF = CNT_W'(RST_HALF_DEF)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             enable,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic             sync,
`endif
  input  logic             wr_vld,
  input  logic [CNT_W-1:0] wr_half,
  output logic             pend_vld,
  output logic             divided_clock,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] pend;
  // After reset, stop or sync the first boundary is a silent low half,
  // so the first rising edge lands 2*H cycles after the restart.
  logic             first_half;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt           <= '0;
      half          <= RST_HALF;
      pend          <= '0;
      pend_vld      <= 1'b0;
      divided_clock <= 1'b0;
      tick          <= 1'b0;
      first_half    <= 1'b1;
    end else begin
`ifdef CLKDIV_PHASE_SYNC_EN
      if (sync) begin
        cnt           <= '0;
        divided_clock <= 1'b0;
        tick          <= 1'b0;
        first_half    <= 1'b1;
        if (pend_vld) begin
          half     <= pend;
          pend_vld <= 1'b0;
        end
      end else
`endif
      if (half == '0) begin
        cnt           <= '0;
        divided_clock <= 1'b0;
        tick          <= 1'b0;
        first_half    <= 1'b1;
        if (pend_vld) begin
          half     <= pend;
          pend_vld <= 1'b0;
        end
      end else if (enable) begin
        if (cnt == half - ONE) begin
          cnt        <= '0;
          first_half <= 1'b0;
          if (first_half) begin
            tick <= 1'b0;
          end else begin
            divided_clock <= ~divided_clock;
            tick          <= ~divided_clock;
          end
          if (pend_vld) begin
            half     <= pend;
            pend_vld <= 1'b0;
          end
        end else begin
          cnt  <= cnt + ONE;
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end

      // Only accepted while pend_vld is low, so it never collides with an apply above.
      if (wr_vld) begin
        pend     <= wr_half;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH run-time programmable 50% clock dividers with per-channel rising-edge tick strobes.
// Latency: first rising edge 2*H cycles after reset/restart; new half applied at the next toggle boundary.
// Backpressure: CfgReady = no update pending on CfgCh; out-of-range channels always accept and discard. Option: CLKDIV_PHASE_SYNC_EN.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int               NUM_CH   = 4,
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_HALF = CNT_W'(RST_HALF_DEF),
  parameter int               CH_W     = ch_width(NUM_CH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              CfgValid,
  input  logic [CH_W-1:0]   CfgCh,
  input  logic [CNT_W-1:0]  CfgHalf,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic              SyncReq,
`endif
  output logic              CfgReady,
  output logic [NUM_CH-1:0] DividedClock,
  output logic [NUM_CH-1:0] Tick
);

  localparam int IDX_N = 1 << CH_W;

  logic [NUM_CH-1:0] pend_vld;
  logic [NUM_CH-1:0] wr_vld;
  logic [IDX_N-1:0]  pend_map;

  // Indices beyond NUM_CH read as never-pending so those writes are accepted and dropped.
  for (genvar i = 0; i < IDX_N; i++) begin : g_map
    if (i < NUM_CH) begin : g_in
      assign pend_map[i] = pend_vld[i];
    end else begin : g_out
      assign pend_map[i] = 1'b0;
    end
  end

  assign CfgReady = ~pend_map[CfgCh];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_vld[i] = CfgValid && CfgReady && (CfgCh == CH_W'(i));

    clock_divider_channel #(
      .CNT_W    (CNT_W),
      .RST_HALF (RST_HALF)
    ) u_ch (
      .Clock         (Clock),
      .Reset         (Reset),
      .enable        (Enable),
`ifdef CLKDIV_PHASE_SYNC_EN
      .sync          (SyncReq),
`endif
      .wr_vld        (wr_vld[i]),
      .wr_half       (CfgHalf),
      .pend_vld      (pend_vld[i]),
      .divided_clock (DividedClock[i]),
      .tick          (Tick[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed self-checking bench for clock_divider_multi with RST_HALF=4 on four channels.
module tb_clock_divider_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int CH_W   = 2;

  logic              Clock;
  logic              Reset;
  logic              Enable;
  logic              CfgValid;
  logic [CH_W-1:0]   CfgCh;
  logic [CNT_W-1:0]  CfgHalf;
  logic              CfgReady;
  logic [NUM_CH-1:0] DividedClock;
  logic [NUM_CH-1:0] Tick;
`ifdef CLKDIV_PHASE_SYNC_EN
  logic              SyncReq;
`endif

  int checks;
  int failures;
  int cyc;

  clock_divider_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .RST_HALF (32'd4),
    .CH_W     (CH_W)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Enable       (Enable),
    .CfgValid     (CfgValid),
    .CfgCh        (CfgCh),
    .CfgHalf      (CfgHalf),
`ifdef CLKDIV_PHASE_SYNC_EN
    .SyncReq      (SyncReq),
`endif
    .CfgReady     (CfgReady),
    .DividedClock (DividedClock),
    .Tick         (Tick)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: output high for h cycles starting at 'start', period 2h.
  function automatic logic dref(input int k, input int start, input int h);
    return (k >= start) && (((k - start) / h) % 2 == 0);
  endfunction

  function automatic logic tref(input int k, input int start, input int h);
    return (k >= start) && ((k - start) % (2 * h) == 0);
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Enable   = 1'b1;
    CfgValid = 1'b0;
    CfgCh    = '0;
    CfgHalf  = '0;
`ifdef CLKDIV_PHASE_SYNC_EN
    SyncReq  = 1'b0;
`endif
    Reset = 1'b0;
    #1;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    logic [NUM_CH-1:0] ed, et;
    Enable   = 1'b1;
    CfgValid = 1'b0;
    CfgCh    = '0;
    CfgHalf  = '0;
`ifdef CLKDIV_PHASE_SYNC_EN
    SyncReq  = 1'b0;
`endif
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    #2;
    checks++;
    if (DividedClock !== '0) begin
      failures++;
      $display("FAIL reset_dclk got=%b exp=0000", DividedClock);
    end
    checks++;
    if (Tick !== '0) begin
      failures++;
      $display("FAIL reset_tick got=%b exp=0000", Tick);
    end
    checks++;
    if (CfgReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", CfgReady);
    end
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    cyc   = 0;
    for (int k = 1; k <= 26; k++) begin
      step();
      ed = {NUM_CH{dref(k, 8, 4)}};
      et = {NUM_CH{tref(k, 8, 4)}};
      checks++;
      if (DividedClock !== ed || Tick !== et) begin
        failures++;
        $display("FAIL reset_run cyc=%0d dclk=%b tick=%b exp dclk=%b tick=%b", k, DividedClock, Tick, ed, et);
      end
    end
  endtask

  task automatic test_reload();
    logic ed, et;
    do_reset();
    while (cyc < 9) step();
    CfgValid = 1'b1;
    CfgCh    = 2'd1;
    CfgHalf  = 32'd2;
    #1;
    checks++;
    if (CfgReady !== 1'b1) begin
      failures++;
      $display("FAIL reload_ready_pre got=%b exp=1", CfgReady);
    end
    for (int k = 10; k <= 21; k++) begin
      step();
      CfgValid = 1'b0;
      #1;
      ed = (k < 12) ? 1'b1 : dref(k, 14, 2);
      et = tref(k, 14, 2);
      checks++;
      if (DividedClock[1] !== ed || Tick[1] !== et) begin
        failures++;
        $display("FAIL reload_ch1 cyc=%0d dclk=%b tick=%b exp dclk=%b tick=%b", k, DividedClock[1], Tick[1], ed, et);
      end
      if (k == 11 || k == 12) begin
        checks++;
        if (CfgReady !== (k == 12)) begin
          failures++;
          $display("FAIL reload_ready cyc=%0d got=%b exp=%b", k, CfgReady, (k == 12));
        end
      end
    end
  endtask

  task automatic test_stop_restart();
    logic ed, et;
    do_reset();
    while (cyc < 8) step();
    CfgValid = 1'b1;
    CfgCh    = 2'd2;
    CfgHalf  = 32'd0;
    for (int k = 9; k <= 31; k++) begin
      step();
      CfgValid = 1'b0;
      #1;
      ed = (k < 12) ? 1'b1 : dref(k, 28, 3);
      et = tref(k, 28, 3);
      checks++;
      if (DividedClock[2] !== ed || Tick[2] !== et) begin
        failures++;
        $display("FAIL stop_ch2 cyc=%0d dclk=%b tick=%b exp dclk=%b tick=%b", k, DividedClock[2], Tick[2], ed, et);
      end
      if (k == 21 || k == 22) begin
        checks++;
        if (CfgReady !== (k == 22)) begin
          failures++;
          $display("FAIL stop_ready cyc=%0d got=%b exp=%b", k, CfgReady, (k == 22));
        end
      end
      if (k == 20) begin
        CfgValid = 1'b1;
        CfgHalf  = 32'd3;
      end
    end
  endtask

  task automatic test_enable_freeze();
    logic [NUM_CH-1:0] ed, et;
    int keff;
    do_reset();
    while (cyc < 8) step();
    for (int k = 9; k <= 30; k++) begin
      step();
      keff = (k < 10) ? k : ((k <= 14) ? 9 : k - 5);
      ed = {NUM_CH{dref(keff, 8, 4)}};
      et = (k >= 10 && k <= 14) ? '0 : {NUM_CH{tref(keff, 8, 4)}};
      checks++;
      if (DividedClock !== ed || Tick !== et) begin
        failures++;
        $display("FAIL enable_freeze cyc=%0d dclk=%b tick=%b exp dclk=%b tick=%b", k, DividedClock, Tick, ed, et);
      end
      if (k == 9)  Enable = 1'b0;
      if (k == 14) Enable = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [NUM_CH-1:0] ed, et;
    do_reset();
    while (cyc < 4) step();
    CfgValid = 1'b1;
    CfgCh    = 2'd1;
    CfgHalf  = 32'd2;
    step();
    CfgHalf = 32'd7;
    #1;
    checks++;
    if (CfgReady !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_busy got=%b exp=0", CfgReady);
    end
    step();
    CfgCh   = 2'd3;
    CfgHalf = 32'd2;
    #1;
    checks++;
    if (CfgReady !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_ch3 got=%b exp=1", CfgReady);
    end
    step();
    CfgValid = 1'b0;
    CfgCh    = 2'd1;
    for (int k = 7; k <= 20; k++) begin
      if (k > 7) step();
      ed = {dref(k, 8, 2), dref(k, 8, 4), dref(k, 8, 2), dref(k, 8, 4)};
      et = {tref(k, 8, 2), tref(k, 8, 4), tref(k, 8, 2), tref(k, 8, 4)};
      checks++;
      if (DividedClock !== ed || Tick !== et) begin
        failures++;
        $display("FAIL b2b_run cyc=%0d dclk=%b tick=%b exp dclk=%b tick=%b", k, DividedClock, Tick, ed, et);
      end
    end
    checks++;
    if (CfgReady !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_after got=%b exp=1", CfgReady);
    end
  endtask

`ifdef CLKDIV_PHASE_SYNC_EN
  task automatic test_sync();
    logic [NUM_CH-1:0] ed, et;
    do_reset();
    CfgValid = 1'b1;
    CfgCh    = 2'd0;
    CfgHalf  = 32'd2;
    step();
    CfgValid = 1'b0;
    while (cyc < 13) step();
    SyncReq = 1'b1;
    for (int k = 14; k <= 31; k++) begin
      step();
      SyncReq = 1'b0;
      ed = {dref(k, 22, 4), dref(k, 22, 4), dref(k, 22, 4), dref(k, 18, 2)};
      et = {tref(k, 22, 4), tref(k, 22, 4), tref(k, 22, 4), tref(k, 18, 2)};
      checks++;
      if (DividedClock !== ed || Tick !== et) begin
        failures++;
        $display("FAIL sync_run cyc=%0d dclk=%b tick=%b exp dclk=%b tick=%b", k, DividedClock, Tick, ed, et);
      end
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    test_reset();
    test_reload();
    test_stop_restart();
    test_enable_freeze();
    test_back_to_back();
`ifdef CLKDIV_PHASE_SYNC_EN
    test_sync();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
